// File: rtl/debug_proto_pkg.sv
// Shared definitions for the debug-unit byte protocol: command bytes, dump framing and
// the state encoding used by both the host driver and the on-chip debug unit.
package debug_proto_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DUMP_WORDS     = 65;
  localparam int unsigned STATE_W        = 10;

  // IDLE is all-zero so the LED bank is dark and every output reads 0 out of reset;
  // every other state owns one bit.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 10'h000,
    ST_TX_LOAD    = 10'h002,
    ST_TX_LEN     = 10'h004,
    ST_PROG_FETCH = 10'h008,
    ST_TX_PROG    = 10'h010,
    ST_TX_EXEC    = 10'h020,
    ST_RX_DUMP    = 10'h040,
    ST_STEP_WAIT  = 10'h080,
    ST_DONE       = 10'h100,
    ST_ERROR      = 10'h200
  } state_e;

endpackage

// File: rtl/dump_word_assembler.sv
// Packs the returned dump byte stream (MSB first) into words and emits one capture
// strobe per completed word; o_done accompanies the strobe of the final word.
module dump_word_assembler import debug_proto_pkg::*; #(
  parameter int unsigned BYTE      = 8,
  parameter int unsigned DWORD     = 32,
  parameter int unsigned CAP_ADDR  = 7,
  parameter int unsigned NUM_WORDS = DUMP_WORDS
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_byte_valid,
  input  logic [BYTE-1:0]     i_byte,
  output logic                o_cap_we,
  output logic [CAP_ADDR-1:0] o_cap_addr,
  output logic [DWORD-1:0]    o_cap_data,
  output logic                o_done
);

  localparam int unsigned CNT_W   = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHIFT_W = DWORD - BYTE;

  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CAP_ADDR-1:0] word_idx_q, word_idx_d;
  logic                cap_we_q, cap_we_d;
  logic [CAP_ADDR-1:0] cap_addr_q, cap_addr_d;
  logic [DWORD-1:0]    cap_data_q, cap_data_d;
  logic                done_q, done_d;

  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    cap_we_d   = 1'b0;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    done_d     = 1'b0;
    if (i_clear) begin
      shift_d    = '0;
      byte_cnt_d = '0;
      word_idx_d = '0;
    end else if (i_byte_valid) begin
      shift_d = {shift_q[SHIFT_W-BYTE-1:0], i_byte};
      if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
        byte_cnt_d = '0;
        cap_we_d   = 1'b1;
        cap_addr_d = word_idx_q;
        cap_data_d = {shift_q, i_byte};
        word_idx_d = word_idx_q + 1'b1;
        done_d     = (word_idx_q == CAP_ADDR'(NUM_WORDS - 1));
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      cap_we_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      cap_we_q   <= cap_we_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      done_q     <= done_d;
    end
  end

  assign o_cap_we   = cap_we_q;
  assign o_cap_addr = cap_addr_q;
  assign o_cap_data = cap_data_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_host_driver.sv
// On-chip debug host: streams a ROM program to the debug unit over the UART byte
// handshake, issues run/step, and captures the returned dump as words.
module debug_host_driver import debug_proto_pkg::*; #(
  parameter int unsigned BYTE           = 8,
  parameter int unsigned DWORD          = 32,
  parameter int unsigned PROG_ADDR      = 8,
  parameter int unsigned REG_WORDS      = 32,
  parameter int unsigned MEM_WORDS      = 32,
  parameter int unsigned CAP_ADDR       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned STATE_SIZE     = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_abort,
  input  logic [PROG_ADDR-1:0]  i_prog_len,
  output logic [PROG_ADDR-1:0]  o_prog_addr,
  input  logic [BYTE-1:0]       i_prog_data,
  output logic [BYTE-1:0]       o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  input  logic [BYTE-1:0]       i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_cap_we,
  output logic [CAP_ADDR-1:0]   o_cap_addr,
  output logic [DWORD-1:0]      o_cap_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [STATE_SIZE-1:0] o_state
);

  localparam int unsigned NUM_WORDS = 1 + REG_WORDS + MEM_WORDS;
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic                 step_mode_q, step_mode_d;
  logic                 error_q, error_d;
  logic                 fetch_wait_q, fetch_wait_d;
  logic [PROG_ADDR-1:0] prog_addr_q, prog_addr_d;
  logic [PROG_ADDR-1:0] sent_q, sent_d;
  logic [BYTE-1:0]      tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [TO_W-1:0]      idle_q, idle_d;

  logic                 tx_done_ok;
  logic [BYTE-1:0]      exec_cmd;
  logic                 asm_clear;
  logic                 asm_valid;
  logic                 asm_done;

  // A done tick coinciding with our own start pulse cannot belong to this byte.
  assign tx_done_ok = i_tx_done && !tx_start_q;
  assign exec_cmd   = step_mode_q ? BYTE'(CMD_STEP) : BYTE'(CMD_CONT);
  assign asm_valid  = i_rx_done && (state_q == ST_RX_DUMP) && !asm_done;

  always_comb begin
    state_d      = state_q;
    step_mode_d  = step_mode_q;
    error_d      = error_q;
    fetch_wait_d = fetch_wait_q;
    prog_addr_d  = prog_addr_q;
    sent_d       = sent_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    idle_d       = '0;
    asm_clear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          step_mode_d = i_step_mode;
          error_d     = 1'b0;
          prog_addr_d = '0;
          sent_d      = '0;
          state_d     = ST_TX_LOAD;
          tx_start_d  = 1'b1;
          tx_data_d   = BYTE'(CMD_LOAD);
        end
      end
      ST_TX_LOAD: begin
        if (tx_done_ok) begin
          state_d    = ST_TX_LEN;
          tx_start_d = 1'b1;
          tx_data_d  = BYTE'(i_prog_len);
        end
      end
      ST_TX_LEN: begin
        if (tx_done_ok) begin
          if (i_prog_len == '0) begin
            state_d    = ST_TX_EXEC;
            tx_start_d = 1'b1;
            tx_data_d  = exec_cmd;
          end else begin
            state_d      = ST_PROG_FETCH;
            fetch_wait_d = 1'b0;
          end
        end
      end
      ST_PROG_FETCH: begin
        // First cycle lets the ROM register the address; the second captures its data.
        if (fetch_wait_q) begin
          fetch_wait_d = 1'b0;
          state_d      = ST_TX_PROG;
          tx_start_d   = 1'b1;
          tx_data_d    = i_prog_data;
        end else begin
          fetch_wait_d = 1'b1;
        end
      end
      ST_TX_PROG: begin
        if (tx_done_ok) begin
          prog_addr_d = prog_addr_q + 1'b1;
          sent_d      = sent_q + 1'b1;
          if (sent_d == i_prog_len) begin
            state_d    = ST_TX_EXEC;
            tx_start_d = 1'b1;
            tx_data_d  = exec_cmd;
          end else begin
            state_d = ST_PROG_FETCH;
          end
        end
      end
      ST_TX_EXEC: begin
        if (tx_done_ok) begin
          state_d   = ST_RX_DUMP;
          asm_clear = 1'b1;
        end
      end
      ST_RX_DUMP: begin
        if (asm_done) begin
          state_d = step_mode_q ? ST_STEP_WAIT : ST_DONE;
        end else if (i_rx_done) begin
          idle_d = '0;
        end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (i_step) begin
          state_d    = ST_TX_EXEC;
          tx_start_d = 1'b1;
          tx_data_d  = BYTE'(CMD_STEP);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      step_mode_q  <= 1'b0;
      error_q      <= 1'b0;
      fetch_wait_q <= 1'b0;
      prog_addr_q  <= '0;
      sent_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      step_mode_q  <= step_mode_d;
      error_q      <= error_d;
      fetch_wait_q <= fetch_wait_d;
      prog_addr_q  <= prog_addr_d;
      sent_q       <= sent_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      idle_q       <= idle_d;
    end
  end

  dump_word_assembler #(
    .BYTE      (BYTE),
    .DWORD     (DWORD),
    .CAP_ADDR  (CAP_ADDR),
    .NUM_WORDS (NUM_WORDS)
  ) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (asm_clear),
    .i_byte_valid (asm_valid),
    .i_byte       (i_rx_data),
    .o_cap_we     (o_cap_we),
    .o_cap_addr   (o_cap_addr),
    .o_cap_data   (o_cap_data),
    .o_done       (asm_done)
  );

  assign o_prog_addr = prog_addr_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign o_done      = (state_q == ST_DONE);
  assign o_error     = error_q;
  assign o_state     = STATE_SIZE'(state_q);

endmodule

// File: tb/tb_debug_host_driver.sv
// Bench for debug_host_driver: UART tx/ROM models, scenario table with randomized
// program and dump contents, plus timeout and mid-transfer reset sequences.
module tb_debug_host_driver;
  import debug_proto_pkg::*;

  localparam int unsigned TO = 100;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_step_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        i_abort = 1'b0;
  logic [7:0]  i_prog_len = '0;
  logic [7:0]  o_prog_addr;
  logic [7:0]  i_prog_data = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic        o_cap_we;
  logic [6:0]  o_cap_addr;
  logic [31:0] o_cap_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [9:0]  o_state;

  always #5 i_clock = ~i_clock;

  debug_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_step_mode (i_step_mode),
    .i_step      (i_step),
    .i_abort     (i_abort),
    .i_prog_len  (i_prog_len),
    .o_prog_addr (o_prog_addr),
    .i_prog_data (i_prog_data),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_cap_we    (o_cap_we),
    .o_cap_addr  (o_cap_addr),
    .o_cap_data  (o_cap_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_state     (o_state)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  logic [7:0]  rom [256];
  logic [7:0]  rom_addr_prev = '0;
  logic [7:0]  tx_log [$];
  logic [6:0]  cap_addr_log [$];
  logic [31:0] cap_data_log [$];
  logic [7:0]  exp_tx [$];
  logic [6:0]  exp_caddr [$];
  logic [31:0] exp_cdata [$];

  int unsigned tx_timer = 0;
  logic [7:0]  tx_cur = '0;
  bit          tx_stale = 1'b0;
  int unsigned overlap_err = 0;
  int unsigned hold_err = 0;
  bit          addr_moved = 1'b0;

  // Synchronous ROM: data for the address seen in one cycle appears in the next.
  always @(negedge i_clock) begin
    i_prog_data = rom[rom_addr_prev];
    rom_addr_prev = o_prog_addr;
  end

  // UART tx: done tick 10 cycles after each start; flags overlap and unstable data.
  always @(negedge i_clock) begin
    i_tx_done = 1'b0;
    if (!i_reset) tx_stale = 1'b1;
    if (tx_timer != 0) begin
      if (o_tx_start) overlap_err++;
      if (!tx_stale && o_tx_data !== tx_cur) hold_err++;
      tx_timer--;
      if (tx_timer == 0) i_tx_done = 1'b1;
    end else if (o_tx_start) begin
      tx_log.push_back(o_tx_data);
      tx_cur = o_tx_data;
      tx_stale = 1'b0;
      tx_timer = 10;
    end
  end

  always @(negedge i_clock) begin
    if (o_cap_we) begin
      cap_addr_log.push_back(o_cap_addr);
      cap_data_log.push_back(o_cap_data);
    end
    if (o_prog_addr != 8'h00) addr_moved = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int unsigned gap);
    tick(gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick(1);
    i_rx_done = 1'b0;
  endtask

  task automatic wait_state(input logic [9:0] st, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (o_state !== st && n < budget) begin
      tick(1);
      n++;
    end
    check(name, o_state, st);
  endtask

  function automatic logic any_output();
    return |{o_prog_addr, o_tx_data, o_tx_start, o_cap_we, o_cap_addr, o_cap_data,
             o_busy, o_done, o_error, o_state};
  endfunction

  task automatic clear_logs();
    tx_log.delete(); cap_addr_log.delete(); cap_data_log.delete();
    exp_tx.delete(); exp_caddr.delete(); exp_cdata.delete();
  endtask

  typedef struct {
    int unsigned len;
    bit          mode;
    int unsigned steps;
    bit          fixed;
    int unsigned exp_tx;
    int unsigned exp_caps;
    logic [9:0]  exp_final;
  } vec_t;

  task automatic run_vec(input vec_t v, input int unsigned idx);
    logic [7:0] dump [260];
    clear_logs();
    if (v.fixed) begin
      rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;
    end else begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    end
    exp_tx.push_back(8'h4C);
    exp_tx.push_back(8'(v.len));
    for (int i = 0; i < int'(v.len); i++) exp_tx.push_back(rom[i]);
    exp_tx.push_back(v.mode ? 8'h53 : 8'h43);
    for (int s = 0; s < int'(v.steps); s++) exp_tx.push_back(8'h53);

    i_prog_len = 8'(v.len);
    i_step_mode = v.mode;
    pulse_start();
    i_step_mode = ~v.mode;
    addr_moved = 1'b0;

    for (int d = 0; d <= int'(v.steps); d++) begin
      wait_state(ST_RX_DUMP, 6000, $sformatf("v%0d_reach_rx_dump%0d", idx, d));
      for (int i = 0; i < 260; i++) begin
        dump[i] = 8'($urandom);
        if (v.fixed && d == 0 && i < 4) dump[i] = (i == 3) ? 8'h14 : 8'h00;
        send_rx(dump[i], $urandom_range(1, 4));
        if (i == 100) begin
          i_start = 1'b1; i_step = 1'b1;
          tick(1);
          i_start = 1'b0; i_step = 1'b0;
          check($sformatf("v%0d_start_ignored_busy", idx), o_state, ST_RX_DUMP);
        end
      end
      for (int w = 0; w < 65; w++) begin
        exp_caddr.push_back(7'(w));
        exp_cdata.push_back({dump[4*w], dump[4*w+1], dump[4*w+2], dump[4*w+3]});
      end
      if (v.mode) begin
        wait_state(ST_STEP_WAIT, 20, $sformatf("v%0d_reach_step_wait%0d", idx, d));
        if (d < int'(v.steps)) begin
          i_step = 1'b1; tick(1); i_step = 1'b0;
        end
      end else begin
        wait_state(ST_DONE, 20, $sformatf("v%0d_reach_done", idx));
      end
    end
    if (v.mode) begin
      i_step = 1'b1; i_abort = 1'b1;
      tick(1);
      i_step = 1'b0; i_abort = 1'b0;
    end
    tick(15);
    check($sformatf("v%0d_final_state", idx), o_state, v.exp_final);
    check($sformatf("v%0d_done_flag", idx), o_done, v.exp_final == ST_DONE);
    check($sformatf("v%0d_busy_flag", idx), o_busy, 0);
    check($sformatf("v%0d_tx_count", idx), tx_log.size(), v.exp_tx);
    check($sformatf("v%0d_cap_count", idx), cap_data_log.size(), v.exp_caps);
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check($sformatf("v%0d_tx_byte%0d", idx, i), tx_log[i], exp_tx[i]);
    for (int i = 0; i < exp_cdata.size() && i < cap_data_log.size(); i++) begin
      check($sformatf("v%0d_cap_addr%0d", idx, i), cap_addr_log[i], exp_caddr[i]);
      check($sformatf("v%0d_cap_data%0d", idx, i), cap_data_log[i], exp_cdata[i]);
    end
    if (v.len == 0) check($sformatf("v%0d_prog_addr_static", idx), addr_moved, 0);
  endtask

  initial begin
    vec_t vecs [5];
    int unsigned n_before;
    vecs[0] = '{len: 3,   mode: 1'b0, steps: 0, fixed: 1'b1, exp_tx: 6,   exp_caps: 65,  exp_final: ST_DONE};
    vecs[1] = '{len: 0,   mode: 1'b0, steps: 0, fixed: 1'b0, exp_tx: 3,   exp_caps: 65,  exp_final: ST_DONE};
    vecs[2] = '{len: 1,   mode: 1'b1, steps: 2, fixed: 1'b0, exp_tx: 6,   exp_caps: 195, exp_final: ST_IDLE};
    vecs[3] = '{len: 255, mode: 1'b0, steps: 0, fixed: 1'b0, exp_tx: 258, exp_caps: 65,  exp_final: ST_DONE};
    vecs[4] = '{len: 5,   mode: 1'b1, steps: 0, fixed: 1'b0, exp_tx: 8,   exp_caps: 65,  exp_final: ST_IDLE};
    for (int i = 0; i < 256; i++) rom[i] = '0;

    tick(3);
    check("reset_outputs_zero", any_output(), 0);
    i_reset = 1'b1;
    tick(2);

    for (int unsigned k = 0; k < 5; k++) run_vec(vecs[k], k);
    check("tx_start_overlap", overlap_err, 0);
    check("tx_data_hold", hold_err, 0);

    // Timeout: 10 bytes then silence.
    clear_logs();
    i_prog_len = 8'd0; i_step_mode = 1'b0;
    pulse_start();
    wait_state(ST_RX_DUMP, 200, "to_reach_rx_dump");
    for (int i = 0; i < 10; i++) send_rx(8'($urandom), 2);
    tick(99);
    check("to_not_yet", o_state, ST_RX_DUMP);
    tick(1);
    check("to_error_state", o_state, ST_ERROR);
    check("to_error_flag", o_error, 1);
    check("to_busy_low", o_busy, 0);
    check("to_cap_count", cap_data_log.size(), 2);
    pulse_start();
    check("to_error_cleared", o_error, 0);
    check("to_restart_state", o_state, ST_TX_LOAD);
    i_reset = 1'b0; tick(15); i_reset = 1'b1; tick(2);

    // Reset in the middle of program transmission.
    clear_logs();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    i_prog_len = 8'd5;
    pulse_start();
    wait_state(ST_TX_PROG, 200, "rst_reach_tx_prog");
    tick(3);
    i_reset = 1'b0;
    tick(1);
    check("rst_txprog_state", o_state, ST_IDLE);
    check("rst_txprog_outputs_zero", any_output(), 0);
    i_reset = 1'b1;
    n_before = tx_log.size();
    tick(20);
    check("rst_txprog_stray_state", o_state, ST_IDLE);
    check("rst_txprog_no_tx", tx_log.size(), n_before);

    // Reset in the middle of dump reception.
    clear_logs();
    i_prog_len = 8'd0;
    pulse_start();
    wait_state(ST_RX_DUMP, 200, "rst_reach_rx_dump");
    for (int i = 0; i < 6; i++) send_rx(8'($urandom), 1);
    i_reset = 1'b0;
    tick(1);
    check("rst_rx_state", o_state, ST_IDLE);
    check("rst_rx_outputs_zero", any_output(), 0);
    i_reset = 1'b1;
    n_before = cap_data_log.size();
    for (int i = 0; i < 4; i++) send_rx(8'hAA, 1);
    tick(3);
    check("rst_rx_stray_state", o_state, ST_IDLE);
    check("rst_rx_no_capture", cap_data_log.size(), n_before);
    check("end_tx_start_overlap", overlap_err, 0);
    check("end_tx_data_hold", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_host_driver.md
Name: debug_host_driver

Overview:
- On-chip initiator for the debug-unit byte protocol: plays the host-PC role over a UART byte stream, for board self-test and simulation without a PC.
- Loads a program from a local program ROM, issues a run or step command, then collects the returned dump (PC, register bank, data memory) as 32-bit words on a capture write port.
- Sits on the far side of a UART pair, driving the UART's tx byte handshake and consuming its rx byte strobes.

Parameters:
- BYTE, 8, UART byte width.
- DWORD, 32, dump word width.
- PROG_ADDR, 8, program ROM address width.
- REG_WORDS, 32, register words per dump.
- MEM_WORDS, 32, data-memory words per dump.
- CAP_ADDR, 7, capture address width; must satisfy 2^CAP_ADDR >= 1+REG_WORDS+MEM_WORDS.
- TIMEOUT_CYCLES, 2000000, maximum idle clocks between dump bytes.
- STATE_SIZE, 10, one-hot state width.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins load-then-execute; accepted only in IDLE, DONE or ERROR.
- i_step_mode  in  1  sampled with i_start; 1 = step, 0 = continuous.
- i_step  in  1  pulse; requests the next step; honoured only in STEP_WAIT.
- i_abort  in  1  pulse; STEP_WAIT -> IDLE.
- i_prog_len  in  PROG_ADDR  program byte count, 1..255; 0 skips the payload.
- o_prog_addr  out  PROG_ADDR  ROM read address.
- i_prog_data  in  BYTE  ROM data, valid one cycle after o_prog_addr.
- o_tx_data  out  BYTE  byte to the UART tx.
- o_tx_start  out  1  one-cycle tx request.
- i_tx_done  in  1  UART tx done tick.
- i_rx_data  in  BYTE  UART rx byte.
- i_rx_done  in  1  UART rx done tick.
- o_cap_we  out  1  capture write strobe.
- o_cap_addr  out  CAP_ADDR  0 = PC, 1..REG_WORDS = registers, then memory words.
- o_cap_data  out  DWORD  assembled word.
- o_busy  out  1  high outside IDLE, DONE and ERROR.
- o_done  out  1  high in DONE.
- o_error  out  1  sticky timeout flag.
- o_state  out  STATE_SIZE  one-hot state, for LEDs.

Behaviour:
- Reset (i_reset==0 at a clock edge): state IDLE; all outputs 0; all counters 0.
- Command bytes: 0x4C 'L' load, 0x43 'C' continuous run, 0x53 'S' step.
- Dump framing:
  - (1+REG_WORDS+MEM_WORDS)*4 bytes, default 260.
  - Each word is sent MSB first; PC first, then r0..r31, then mem0..mem31.
- States: IDLE, TX_LOAD, TX_LEN, PROG_FETCH, TX_PROG, TX_EXEC, RX_DUMP, STEP_WAIT, DONE, ERROR.
- Tx handshake (every TX_* state):
  - On entry, drive o_tx_data and pulse o_tx_start for exactly one cycle.
  - Hold o_tx_data stable until i_tx_done, then advance on that same edge.
  - Never raise o_tx_start while a byte is in flight.
- Sequence:
  - i_start latches i_step_mode and clears o_error.
  - TX_LOAD sends 'L'. TX_LEN sends i_prog_len; if it is 0, go directly to TX_EXEC.
  - PROG_FETCH: present the address, wait one cycle for data, then TX_PROG sends the byte.
  - Increment the address; loop until i_prog_len bytes have been sent.
  - TX_EXEC sends 'S' in step mode, else 'C'. Then RX_DUMP.
- RX_DUMP:
  - On each i_rx_done: shift = {shift[23:0], i_rx_data} and increment the byte count.
  - On every 4th byte: pulse o_cap_we for one cycle with o_cap_data = completed word and o_cap_addr = word index.
  - After the last word, go to STEP_WAIT (step mode) or DONE.
- STEP_WAIT:
  - i_step -> TX_EXEC ('S'), with the word index reset to 0.
  - i_abort -> IDLE.
  - If both pulse in the same cycle, i_abort wins.
- Timeout:
  - An idle counter runs in RX_DUMP and resets on each i_rx_done.
  - On reaching TIMEOUT_CYCLES: go to ERROR, set o_error, and discard any partial word (no o_cap_we).
  - A lost tx done tick does not time out. This is a documented limitation.
- Ignored events:
  - i_rx_done outside RX_DUMP is dropped.
  - i_start while busy is ignored.
  - i_step outside STEP_WAIT is ignored.
- Reset mid-transfer: immediate return to IDLE. The UART may still finish the byte in flight; its done tick is ignored.
- Program address wraps modulo 2^PROG_ADDR; with i_prog_len <= 255 no wrap occurs.

Decomposition:
- Shared package debug_proto_pkg: command byte constants, dump word count, bytes per word, and the state encoding. The debug unit uses the same package.
- One natural sub-module, dump_word_assembler: byte shift register, byte/word counters and capture strobe generation, with clear and done outputs.

Test Plan:
- Load 3 bytes {0x11,0x22,0x33}, continuous mode, with a UART model that asserts i_tx_done 10 cycles after o_tx_start -> tx stream 0x4C,0x03,0x11,0x22,0x33,0x43, and exactly one o_tx_start per byte.
- Feed 260 dump bytes, first four 0x00,0x00,0x00,0x14 -> o_cap_addr 0 with o_cap_data 0x00000014; 65 o_cap_we pulses in total; then o_done=1 and o_busy=0.
- Step mode, two i_step pulses after the first dump -> tx 'S' three times in total and three full dumps captured; i_abort then gives IDLE.
- Stop rx after 10 dump bytes, with TIMEOUT_CYCLES=100 -> ERROR 100 cycles after the 10th byte, o_error=1, only 2 captures; a following i_start clears o_error.
- Drive i_reset=0 mid TX_PROG, and also mid RX_DUMP -> next cycle in IDLE with all outputs 0; a stray i_tx_done or i_rx_done afterwards causes no transition.
- i_prog_len=0 -> tx 0x4C,0x00,0x43 and no o_prog_addr change; i_start pulsed while busy -> ignored.
